// File: rtl/modport_i2c_slave.sv
// I2C slave: oversamples SCL/SDA, captures address and write data, ACKs bytes
// and returns the last written byte on reads. SDA is open-drain (0 or z only).
module modport_i2c_slave #(
  parameter bit         ADDR_FILTER_EN = 1'b0,
  parameter logic [6:0] SLAVE_ADDR     = 7'h50
) (
  input  logic       clk,
  input  logic       RESET_IN,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [6:0] ADRESS_OUT,
  output logic [7:0] DATA_OUT
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state;
  logic [2:0] scl_s, sda_s;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw, ack_hi, sda_low;

  // [0],[1] synchronise, [2] is history. Reset loads the live level so a reset
  // in mid-transfer cannot fabricate an edge (and hence a false START/STOP).
  always_ff @(posedge clk) begin
    if (RESET_IN) begin
      scl_s <= {3{SCL}};
      sda_s <= {3{SDA}};
    end else begin
      scl_s <= {scl_s[1:0], SCL};
      sda_s <= {sda_s[1:0], SDA};
    end
  end

  logic scl_rise, scl_fall, sda_in, start, stop, addr_ok;
  assign scl_rise = scl_s[1] & ~scl_s[2];
  assign scl_fall = ~scl_s[1] & scl_s[2];
  assign sda_in   = sda_s[1];
  assign start    = scl_s[1] & scl_s[2] & ~sda_s[1] &  sda_s[2];
  assign stop     = scl_s[1] & scl_s[2] &  sda_s[1] & ~sda_s[2];
  assign addr_ok  = (ADDR_FILTER_EN == 1'b0) || (shreg[6:0] == SLAVE_ADDR);

  assign SDA = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (RESET_IN) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      ack_hi     <= 1'b0;
      sda_low    <= 1'b0;
      ADRESS_OUT <= '0;
      DATA_OUT   <= '0;
    end else if (stop) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sda_low <= 1'b0;
    end else if (start) begin
      state   <= ADDR;
      bit_cnt <= '0;
      shreg   <= '0;
      sda_low <= 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg   <= {shreg[6:0], sda_in};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            rw      <= sda_in;
            bit_cnt <= '0;
            ack_hi  <= 1'b0;
            if (addr_ok) begin
              ADRESS_OUT <= shreg[6:0];
              state      <= ADDR_ACK;
            end else begin
              state <= IGNORE;
            end
          end
        end
        // First fall drives the ACK, second fall ends the 9th clock. For a read
        // that second fall is also where the first data bit goes out.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_hi) begin
            sda_low <= 1'b1;
            ack_hi  <= 1'b1;
          end else if (state == WR_ACK || !rw) begin
            sda_low <= 1'b0;
            bit_cnt <= '0;
            state   <= WR_DATA;
          end else begin
            sda_low <= ~DATA_OUT[7];
            shreg   <= {DATA_OUT[6:0], 1'b0};
            bit_cnt <= 4'd1;
            state   <= RD_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg   <= {shreg[6:0], sda_in};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            DATA_OUT <= {shreg[6:0], sda_in};
            bit_cnt  <= '0;
            ack_hi   <= 1'b0;
            state    <= WR_ACK;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_low <= 1'b0;
            state   <= RD_ACK;
          end else begin
            sda_low <= ~shreg[7];
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_in) begin
            shreg   <= DATA_OUT;
            bit_cnt <= '0;
            state   <= RD_DATA;
          end else begin
            state <= IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modport_i2c_slave.sv
// Directed bench: bit-banged I2C master driving an unfiltered and a filtered slave.
module tb_modport_i2c_slave;
  logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  wire        sda0, sda1;
  logic [6:0] adr0, adr1;
  logic [7:0] dat0, dat1;
  int         pass_cnt = 0, total = 0;

  assign sda0 = m_sda ? 1'bz : 1'b0;
  assign sda1 = m_sda ? 1'bz : 1'b0;
  pullup (sda0);
  pullup (sda1);

  modport_i2c_slave #(.ADDR_FILTER_EN(1'b0), .SLAVE_ADDR(7'h50)) dut0 (
    .clk(clk), .RESET_IN(rst), .SCL(scl), .SDA(sda0), .ADRESS_OUT(adr0), .DATA_OUT(dat0));
  modport_i2c_slave #(.ADDR_FILTER_EN(1'b1), .SLAVE_ADDR(7'h50)) dut1 (
    .clk(clk), .RESET_IN(rst), .SCL(scl), .SDA(sda1), .ADRESS_OUT(adr1), .DATA_OUT(dat1));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]      addr;
    int              n;
    logic [2:0][7:0] d;
    logic            ack1;
    logic [6:0]      e_adr1;
    logic [7:0]      e_dat1;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    if (!scl) begin
      m_sda = 1'b1; cyc(8); scl = 1'b1; cyc(8);
    end
    m_sda = 1'b0; cyc(8); scl = 1'b0; cyc(8);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; cyc(8); scl = 1'b1; cyc(8); m_sda = 1'b1; cyc(8);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; cyc(4); scl = 1'b1; cyc(8); scl = 1'b0; cyc(4);
  endtask

  // One SCL clock with the master driving drv; samples both buses mid-high.
  task automatic clk_sample(input logic drv, output logic s0, output logic s1);
    m_sda = drv; cyc(4); scl = 1'b1; cyc(4);
    s0 = sda0; s1 = sda1;
    cyc(4); scl = 1'b0; cyc(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a0, output logic a1);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    clk_sample(1'b1, a0, a1);
  endtask

  task automatic read_byte(output logic [7:0] r);
    logic s0, s1;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      clk_sample(1'b1, s0, s1);
      r = {r[6:0], s0};
    end
  endtask

  initial begin
    logic a0, a1, s0, s1;
    logic [7:0] r;
    vecs[0] = '{addr:7'h3A, n:1, d:{8'h00, 8'h00, 8'hA5}, ack1:1'b0, e_adr1:7'h00, e_dat1:8'h00};
    vecs[1] = '{addr:7'h12, n:3, d:{8'h80, 8'hFF, 8'h01}, ack1:1'b0, e_adr1:7'h00, e_dat1:8'h00};
    vecs[2] = '{addr:7'h51, n:1, d:{8'h00, 8'h00, 8'h99}, ack1:1'b0, e_adr1:7'h00, e_dat1:8'h00};
    vecs[3] = '{addr:7'h50, n:1, d:{8'h00, 8'h00, 8'h99}, ack1:1'b1, e_adr1:7'h50, e_dat1:8'h99};
    vecs[4] = '{addr:7'h3A, n:1, d:{8'h00, 8'h00, 8'hC3}, ack1:1'b0, e_adr1:7'h50, e_dat1:8'h99};

    cyc(4); rst = 1'b0; cyc(8);
    chk("rst_adr0", adr0, 7'h00);
    chk("rst_dat0", dat0, 8'h00);
    chk("rst_adr1", adr1, 7'h00);
    chk("rst_dat1", dat1, 8'h00);
    chk("rst_sda0", sda0, 1'b1);
    chk("rst_sda1", sda1, 1'b1);

    for (int i = 0; i < 5; i++) begin
      start_c();
      write_byte({vecs[i].addr, 1'b0}, a0, a1);
      chk($sformatf("v%0d_addr_ack0", i), a0, 1'b0);
      chk($sformatf("v%0d_addr_ack1", i), a1, !vecs[i].ack1);
      chk($sformatf("v%0d_adr0", i), adr0, vecs[i].addr);
      chk($sformatf("v%0d_adr1", i), adr1, vecs[i].e_adr1);
      for (int j = 0; j < vecs[i].n; j++) begin
        write_byte(vecs[i].d[j], a0, a1);
        chk($sformatf("v%0d_b%0d_ack0", i, j), a0, 1'b0);
        chk($sformatf("v%0d_b%0d_ack1", i, j), a1, !vecs[i].ack1);
        chk($sformatf("v%0d_b%0d_dat0", i, j), dat0, vecs[i].d[j]);
        chk($sformatf("v%0d_b%0d_dat1", i, j), dat1, vecs[i].e_dat1);
      end
      stop_c();
      chk($sformatf("v%0d_stop_adr0", i), adr0, vecs[i].addr);
      chk($sformatf("v%0d_stop_dat0", i), dat0, vecs[i].d[vecs[i].n-1]);
    end

    // Write 3A/C3, repeated START, read back twice (ACK then NACK), then ignore.
    start_c();
    write_byte({7'h3A, 1'b0}, a0, a1);
    write_byte(8'hC3, a0, a1);
    chk("rd_pre_ack0", a0, 1'b0);
    start_c();
    write_byte({7'h3A, 1'b1}, a0, a1);
    chk("rd_addr_ack0", a0, 1'b0);
    chk("rd_addr_ack1", a1, 1'b1);
    read_byte(r);
    chk("rd_byte0", r, 8'hC3);
    clk_sample(1'b0, s0, s1);
    read_byte(r);
    chk("rd_byte1", r, 8'hC3);
    clk_sample(1'b1, s0, s1);
    chk("rd_nack_released", s0, 1'b1);
    read_byte(r);
    chk("ignore_released", r, 8'hFF);
    stop_c();
    chk("rd_adr0", adr0, 7'h3A);
    chk("rd_dat0", dat0, 8'hC3);
    chk("rd_adr1", adr1, 7'h50);
    chk("rd_dat1", dat1, 8'h99);

    // Reset pulse during the 4th data bit of a write.
    start_c();
    write_byte({7'h77, 1'b0}, a0, a1);
    chk("mr_addr_ack0", a0, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    m_sda = 1'b0; cyc(2); rst = 1'b1; cyc(1); rst = 1'b0; cyc(1);
    scl = 1'b1; cyc(8); scl = 1'b0; cyc(4);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    clk_sample(1'b1, s0, s1);
    chk("mr_sda0", s0, 1'b1);
    chk("mr_adr0", adr0, 7'h00);
    chk("mr_dat0", dat0, 8'h00);
    chk("mr_adr1", adr1, 7'h00);
    chk("mr_dat1", dat1, 8'h00);
    stop_c();
    start_c();
    write_byte({7'h55, 1'b0}, a0, a1);
    chk("post_addr_ack0", a0, 1'b0);
    chk("post_addr_ack1", a1, 1'b1);
    write_byte(8'h66, a0, a1);
    chk("post_data_ack0", a0, 1'b0);
    stop_c();
    chk("post_adr0", adr0, 7'h55);
    chk("post_dat0", dat0, 8'h66);
    chk("post_adr1", adr1, 7'h00);
    chk("post_dat1", dat1, 8'h00);
    chk("post_sda0", sda0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
